// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// sticky fault codes, the pc_control request bundle and a saturating-increment helper.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      RUN    = 3'd1,
      WAIT   = 3'd2,
      HALTED = 3'd3,
      FAULT  = 3'd4
   } state_t;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

   localparam logic [7:0]  WAIT_SAT = 8'hFF;
   localparam logic [15:0] CNT_SAT  = 16'hFFFF;

   // Next-PC candidates handed over by pc_control for the instruction at pc.
   typedef struct packed {
      logic [15:0] next_pc;
      logic [15:0] seq_pc;
      logic        is_branch;
      logic        halt;
   } pc_req_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == CNT_SAT) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pc_wait_timer.sv
// Saturating 8-bit counter of consecutive instruction-memory stall cycles.
// expired flags that one more stall cycle would bring the count to WAIT_MAX (0 = never).
module pc_wait_timer
   import pc_seq_pkg::*;
#(
   parameter logic [7:0] WAIT_MAX = 8'd255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [7:0] cnt;

   // clr together with inc restarts the count at one (first stall cycle seen in RUN).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 8'd0;
      else if (clr)
         cnt <= inc ? 8'd1 : 8'd0;
      else if (inc && cnt != WAIT_SAT)
         cnt <= cnt + 8'd1;
   end

   assign expired = (WAIT_MAX != 8'd0) && (({1'b0, cnt} + 9'd1) >= {1'b0, WAIT_MAX});

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: commits, holds, halts or faults each cycle.
// Optional perf counters built only when PC_SEQ_PERF_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter logic [7:0]  WAIT_MAX  = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] next_pc,
   input  logic [15:0] seq_pc,
   input  logic        is_branch,
   input  logic        halt,
   input  logic        imem_rdy,
   input  logic        resume,
   output logic [15:0] pc,
   output logic        fetch_valid,
   output logic        redirect,
   output logic        halted,
   output logic [1:0]  fault_code,
   output logic [15:0] retired_cnt,
   output logic [15:0] taken_cnt
);

   state_t      state, state_nxt;
   logic [15:0] pc_nxt;
   logic [1:0]  fault_nxt;
   logic        tmr_clr, tmr_inc, tmr_expired;
   pc_req_t     req;

   assign req = '{next_pc: next_pc, seq_pc: seq_pc, is_branch: is_branch, halt: halt};

   pc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc         <= RESET_VEC;
         fault_code <= FLT_NONE;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         fault_code <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      fault_nxt   = fault_code;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      fetch_valid = 1'b0;
      redirect    = 1'b0;
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            fetch_valid = imem_rdy;
            // Stall outranks halt and misalignment: the instruction is re-evaluated once ready.
            if (!imem_rdy) begin
               state_nxt = WAIT;
               tmr_clr   = 1'b1;
               tmr_inc   = 1'b1;
            end else if (req.halt) begin
               state_nxt = HALTED;
            end else if (req.next_pc[0]) begin
               state_nxt = FAULT;
               fault_nxt = FLT_MISALIGN;
            end else begin
               pc_nxt   = req.next_pc;
               redirect = req.is_branch && (req.next_pc != req.seq_pc);
            end
         end
         WAIT: begin
            if (imem_rdy) begin
               state_nxt = RUN;
               tmr_clr   = 1'b1;
            end else begin
               tmr_inc = 1'b1;
               if (tmr_expired) begin
                  state_nxt = FAULT;
                  fault_nxt = FLT_TIMEOUT;
               end
            end
         end
         HALTED: begin
            if (resume) begin
               pc_nxt    = req.seq_pc;
               state_nxt = RUN;
            end
         end
         FAULT: ;
         default: state_nxt = BOOT;
      endcase
   end

   assign halted = (state == HALTED);

`ifdef PC_SEQ_PERF_EN
   logic retire;

   // HLT retires; a misaligned-target instruction does not.
   assign retire = (state == RUN) && imem_rdy && (halt || !next_pc[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 16'h0000;
         taken_cnt   <= 16'h0000;
      end else begin
         if (retire)   retired_cnt <= sat_inc16(retired_cnt);
         if (redirect) taken_cnt   <= sat_inc16(taken_cnt);
      end
   end
`else
   assign retired_cnt = 16'h0000;
   assign taken_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (WAIT_MAX=4 so the stall timeout is reachable).
// Counter expectations follow PC_SEQ_PERF_EN when defined.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] next_pc = 16'h0000, seq_pc = 16'h0000;
   logic        is_branch = 1'b0, halt = 1'b0, imem_rdy = 1'b1, resume = 1'b0;
   logic [15:0] pc, retired_cnt, taken_cnt;
   logic        fetch_valid, redirect, halted;
   logic [1:0]  fault_code;

   int n_chk = 0;
   int n_fail = 0;

   pc_sequencer #(.RESET_VEC(16'h0000), .WAIT_MAX(8'd4)) dut (
      .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .seq_pc(seq_pc),
      .is_branch(is_branch), .halt(halt), .imem_rdy(imem_rdy), .resume(resume),
      .pc(pc), .fetch_valid(fetch_valid), .redirect(redirect), .halted(halted),
      .fault_code(fault_code), .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] np, sp;
      logic        br, hl, rdy, res;
      logic [15:0] epc;
      logic        efv, erd, eh;
      logic [1:0]  eflt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [15:0] np, logic [15:0] sp, logic br, logic hl,
                               logic rdy, logic res, logic [15:0] epc, logic efv,
                               logic erd, logic eh, logic [1:0] eflt);
      vec_t v;
      v.np = np; v.sp = sp; v.br = br; v.hl = hl; v.rdy = rdy; v.res = res;
      v.epc = epc; v.efv = efv; v.erd = erd; v.eh = eh; v.eflt = eflt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, compare the pre-edge outputs 1ns later.
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      next_pc = v.np; seq_pc = v.sp; is_branch = v.br; halt = v.hl;
      imem_rdy = v.rdy; resume = v.res;
      #1;
      chk({tag, " pc"}, pc, v.epc);
      chk({tag, " fetch_valid"}, {15'd0, fetch_valid}, {15'd0, v.efv});
      chk({tag, " redirect"}, {15'd0, redirect}, {15'd0, v.erd});
      chk({tag, " halted"}, {15'd0, halted}, {15'd0, v.eh});
      chk({tag, " fault_code"}, {14'd0, fault_code}, {14'd0, v.eflt});
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] ret, input logic [15:0] tkn);
`ifdef PC_SEQ_PERF_EN
      chk({tag, " retired_cnt"}, retired_cnt, ret);
      chk({tag, " taken_cnt"}, taken_cnt, tkn);
`else
      chk({tag, " retired_cnt"}, retired_cnt, 16'h0000);
      chk({tag, " taken_cnt"}, taken_cnt, 16'h0000);
      if (ret == 16'hFFFF && tkn == 16'hFFFF) $display("unreachable");
`endif
   endtask

   // Asynchronous reset mid-cycle with resume asserted; release just after a posedge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0; resume = 1'b1;
      #1;
      chk({tag, " pc"}, pc, 16'h0000);
      chk({tag, " halted"}, {15'd0, halted}, 16'h0000);
      chk({tag, " fault_code"}, {14'd0, fault_code}, 16'h0000);
      chk({tag, " fetch_valid"}, {15'd0, fetch_valid}, 16'h0000);
      chk_cnt(tag, 16'h0000, 16'h0000);
      @(posedge clk);
      #2 rst_n = 1'b1; resume = 1'b0;
   endtask

   initial begin
      // Main run: boot, branches, 3-cycle stall, halt/resume, wrap, stall+halt.
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0010, 16'h0004, 1, 0, 1, 0, 16'h0002, 1, 1, 0, 2'b00));
      vecs.push_back(mk(16'h0040, 16'h0012, 1, 0, 1, 0, 16'h0010, 1, 1, 0, 2'b00));
      vecs.push_back(mk(16'h0020, 16'h0042, 1, 0, 1, 0, 16'h0040, 1, 1, 0, 2'b00));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(16'h0024, 16'h0022, 1, 0, 0, 0, 16'h0020, 0, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0024, 16'h0022, 1, 0, 1, 0, 16'h0020, 0, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0030, 16'h0022, 0, 0, 1, 0, 16'h0020, 1, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0032, 16'h0032, 0, 1, 1, 0, 16'h0030, 1, 0, 0, 2'b00));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(16'h0032, 16'h0032, 0, i[0], 1, 0, 16'h0030, 0, 0, 1, 2'b00));
      vecs.push_back(mk(16'h0032, 16'h0032, 0, 0, 1, 1, 16'h0030, 0, 0, 1, 2'b00));
      vecs.push_back(mk(16'hFFFE, 16'h0034, 1, 0, 1, 0, 16'h0032, 1, 1, 0, 2'b00));
      vecs.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 0, 16'hFFFE, 1, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 1, 1, 0, 16'h0000, 1, 0, 0, 2'b00));
      vecs.push_back(mk(16'h0002, 16'h0002, 0, 0, 1, 0, 16'h0000, 0, 0, 1, 2'b00));

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset pc", pc, 16'h0000);
      chk("reset fetch_valid", {15'd0, fetch_valid}, 16'h0000);
      chk("reset redirect", {15'd0, redirect}, 16'h0000);
      chk("reset halted", {15'd0, halted}, 16'h0000);
      chk("reset fault_code", {14'd0, fault_code}, 16'h0000);
      chk_cnt("reset", 16'h0000, 16'h0000);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));
      chk_cnt("main", 16'd9, 16'd4);

      // Misaligned target: fault sticks, no retire, resume/ready ignored.
      do_reset("rst_halted");
      step(mk(16'h0044, 16'h0002, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 2'b00), "mis_boot");
      step(mk(16'h0044, 16'h0002, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 2'b00), "mis_run");
      step(mk(16'h0045, 16'h0046, 1, 0, 1, 0, 16'h0044, 1, 0, 0, 2'b00), "mis_hit");
      for (int i = 0; i < 3; i++)
         step(mk(16'h0048, 16'h0046, 0, 1, 1, 1, 16'h0044, 0, 0, 0, 2'b01), "mis_hold");
      chk_cnt("mis", 16'd1, 16'd0);

      // Stall timeout after 4 stall cycles (WAIT_MAX=4); 3 is not enough.
      do_reset("rst_fault");
      step(mk(16'h0020, 16'h0002, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 2'b00), "to_boot");
      step(mk(16'h0020, 16'h0002, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 2'b00), "to_run");
      for (int i = 0; i < 4; i++)
         step(mk(16'h0022, 16'h0022, 0, 0, 0, 0, 16'h0020, 0, 0, 0, 2'b00), $sformatf("to_stall%0d", i + 1));
      for (int i = 0; i < 2; i++)
         step(mk(16'h0022, 16'h0022, 0, 0, 1, 1, 16'h0020, 0, 0, 0, 2'b10), "to_hold");
      chk_cnt("to", 16'd1, 16'd0);

      do_reset("rst_timeout");
`ifdef PC_SEQ_PERF_EN
      begin
         logic [15:0] mpc;
         mpc = 16'h0000;
         step(mk(16'h0002, 16'h0002, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 2'b00), "sat_boot");
         for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            next_pc = mpc + 16'd2; seq_pc = mpc + 16'd2; is_branch = 1'b0;
            halt = 1'b0; imem_rdy = 1'b1; resume = 1'b0;
            mpc = mpc + 16'd2;
         end
         @(negedge clk); imem_rdy = 1'b0; #1;
         chk("sat pc", pc, mpc);
         chk("sat retired_cnt", retired_cnt, 16'hFFFF);
         chk("sat taken_cnt", taken_cnt, 16'h0000);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register of the single-cycle core and decides each cycle whether to commit the next-PC computed by pc_control, hold, halt, or fault.
- Sequences reset boot, instruction-memory stalls, the HLT instruction, and misaligned branch targets.
- Sits between pc_control (which supplies the next-PC and PC+2) and the instruction-memory address port.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- WAIT_MAX, 8'd255, max consecutive stall cycles before a timeout fault; 0 disables the timeout.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  16  pc_out from pc_control (taken target or PC+2).
- seq_pc  input  16  pc_update from pc_control (PC+2).
- is_branch  input  1  current instruction is B/BR.
- halt  input  1  current instruction decodes as HLT.
- imem_rdy  input  1  instruction memory has valid data at pc.
- resume  input  1  restart request while halted.
- pc  output  16  current PC, drives imem address and pc_control pc_in.
- fetch_valid  output  1  instruction at pc is executing and committing this cycle.
- redirect  output  1  taken branch committed this cycle.
- halted  output  1  sequencer is in HALTED.
- fault_code  output  2  00 none, 01 misaligned target, 10 imem timeout; sticky.
- retired_cnt  output  16  committed instruction count (see Optional Feature).
- taken_cnt  output  16  committed taken-branch count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, pc=RESET_VEC, wait counter=0, fault_code=00.
  - All 1-bit outputs 0; counters 0.
- States: BOOT, RUN, WAIT, HALTED, FAULT. All outputs are registered state or decode of state plus inputs; no combinational path from next_pc to pc.
- BOOT: fetch_valid=0; next cycle go to RUN; pc unchanged.
- RUN: fetch_valid = imem_rdy. Priority, highest first:
  1. !imem_rdy: go to WAIT, pc holds, wait counter=1.
  2. halt: go to HALTED, pc holds at the HLT address; the HLT instruction counts as retired.
  3. next_pc[0]=1: go to FAULT with fault_code=01, pc holds; the instruction is not retired.
  4. Otherwise: pc<=next_pc next cycle and retire. redirect=1 when is_branch and next_pc!=seq_pc.
- WAIT: fetch_valid=0, pc holds.
  - imem_rdy=1: go to RUN, clear the counter. The instruction re-evaluates in RUN next cycle, so there is no commit from WAIT.
  - Else the counter increments. When WAIT_MAX!=0 and the counter reaches WAIT_MAX with imem_rdy=0, go to FAULT with fault_code=10.
  - The counter saturates at 8'hFF.
- HALTED: halted=1, fetch_valid=0.
  - resume=1: pc<=seq_pc (HLT address + 2), go to RUN.
  - halt is ignored in this state.
- FAULT: fetch_valid=0, pc frozen, fault_code frozen. Exit only via reset.
- Arithmetic: 16-bit, no carry. PC+2 at 16'hFFFE wraps to 16'h0000 and is legal.
- Simultaneous events:
  - imem_rdy=0 together with halt: stall wins; halt is taken on the ready cycle.
  - resume with rst_n=0: reset wins.
- Reset mid-operation (any state): immediate return to BOOT/RESET_VEC. fault_code clears.

Optional Feature:
- Macro PC_SEQ_PERF_EN.
- Defined:
  - retired_cnt increments on every cycle with fetch_valid=1 whose instruction retires; a misaligned-fault cycle does not count.
  - taken_cnt increments on every cycle with redirect=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: retired_cnt and taken_cnt are constant 16'h0000 and no counter flops are built. Port list is identical in both builds.

Decomposition:
- Package pc_seq_pkg:
  - State encoding constants: BOOT=3'd0, RUN=3'd1, WAIT=3'd2, HALTED=3'd3, FAULT=3'd4.
  - Fault codes: FLT_NONE=2'b00, FLT_MISALIGN=2'b01, FLT_TIMEOUT=2'b10.
- One sub-module, pc_wait_timer: 8-bit saturating stall counter with clear/increment inputs and an expired output compared against WAIT_MAX.
- FSM, PC register and perf counters stay in pc_sequencer.

Test Plan:
- Reset release with imem_rdy=1, next_pc=seq_pc=0x0002 -> cycle 1 BOOT (pc=0x0000, fetch_valid=0); cycle 2 fetch_valid=1; cycle 3 pc=0x0002.
- RUN at pc=0x0010, is_branch=1, next_pc=0x0040, seq_pc=0x0012 -> redirect=1 for one cycle, pc=0x0040 next cycle, taken_cnt +1 with PC_SEQ_PERF_EN.
- imem_rdy=0 for 3 cycles at pc=0x0020 -> fetch_valid=0 and pc=0x0020 throughout; one cycle after imem_rdy=1 returns, commit occurs. With WAIT_MAX=4 and 4 stall cycles -> fault_code=10, pc frozen.
- halt=1 at pc=0x0030 -> halted=1, pc stays 0x0030 for 10 cycles; resume=1 with seq_pc=0x0032 -> pc=0x0032, halted=0.
- next_pc=0x0045 at pc=0x0044 -> fault_code=01, pc=0x0044 frozen, retired_cnt unchanged. rst_n pulse -> pc=RESET_VEC, fault_code=00.
- pc=0xFFFE, next_pc=seq_pc=0x0000 -> pc wraps to 0x0000 with no fault. retired_cnt preset near 0xFFFF saturates at 0xFFFF.
